// File: rtl/temp_zone_ctrl.sv
// Three-zone setpoint controller: inc/dec requests move a clamped setpoint by
// a step chosen by a hysteretic zone FSM that lags the setpoint by one edge.
module temp_zone_ctrl #(
    parameter int unsigned W      = 7,
    parameter int unsigned T_INIT = 26,
    parameter int unsigned T_MIN  = 26,
    parameter int unsigned T_MAX  = 85,
    parameter int unsigned UP01   = 39,
    parameter int unsigned DN10   = 35,
    parameter int unsigned UP12   = 54,
    parameter int unsigned DN21   = 47,
    parameter int unsigned INC0   = 2,
    parameter int unsigned INC1   = 3,
    parameter int unsigned INC2   = 5,
    parameter int unsigned DEC0   = 1,
    parameter int unsigned DEC1   = 2,
    parameter int unsigned DEC2   = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         dec,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] temp,
    output logic [1:0]   zone,
    output logic         at_min,
    output logic         at_max,
    output logic         changed
);

    typedef enum logic [1:0] {
        ZONE0    = 2'd0,
        ZONE1    = 2'd1,
        ZONE2    = 2'd2,
        ZONE_BAD = 2'd3
    } zone_e;

    // Setpoint arithmetic runs one bit wider so sums and borrows never wrap.
    localparam logic [W:0]   MIN_X  = (W+1)'(T_MIN);
    localparam logic [W:0]   MAX_X  = (W+1)'(T_MAX);
    localparam logic [W:0]   INC0_X = (W+1)'(INC0);
    localparam logic [W:0]   INC1_X = (W+1)'(INC1);
    localparam logic [W:0]   INC2_X = (W+1)'(INC2);
    localparam logic [W:0]   DEC0_X = (W+1)'(DEC0);
    localparam logic [W:0]   DEC1_X = (W+1)'(DEC1);
    localparam logic [W:0]   DEC2_X = (W+1)'(DEC2);
    localparam logic [W-1:0] UP01_W = W'(UP01);
    localparam logic [W-1:0] DN10_W = W'(DN10);
    localparam logic [W-1:0] UP12_W = W'(UP12);
    localparam logic [W-1:0] DN21_W = W'(DN21);
    localparam logic [W-1:0] INIT_W = W'(T_INIT);
    localparam logic         INIT_AT_MIN = (T_INIT == T_MIN);
    localparam logic         INIT_AT_MAX = (T_INIT == T_MAX);

    logic [W-1:0] temp_q, temp_d;
    zone_e        zone_q, zone_d;
    logic         at_min_q, at_max_q, changed_q;

    logic [W:0] temp_x, lv_x;
    logic [W:0] inc_step, dec_step;
    logic [W:0] up_sum, up_val;
    logic [W:0] dn_diff, dn_val;
    logic [W:0] lv_val;
    logic       borrow;

    assign temp_x = {1'b0, temp_q};
    assign lv_x   = {1'b0, load_val};

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the case/if structure can leave it unassigned (no latch).
        inc_step = INC0_X;
        dec_step = DEC0_X;
        case (zone_q)
            ZONE1:   begin inc_step = INC1_X; dec_step = DEC1_X; end
            ZONE2:   begin inc_step = INC2_X; dec_step = DEC2_X; end
            default: begin inc_step = INC0_X; dec_step = DEC0_X; end
        endcase
    end

    assign up_sum  = temp_x + inc_step;
    assign up_val  = (up_sum > MAX_X) ? MAX_X : up_sum;
    assign dn_diff = temp_x - dec_step;
    assign borrow  = dn_diff[W];
    assign dn_val  = (borrow || (dn_diff < MIN_X)) ? MIN_X : dn_diff;
    assign lv_val  = (lv_x < MIN_X) ? MIN_X : ((lv_x > MAX_X) ? MAX_X : lv_x);

    always_comb begin
        temp_d = temp_q;
        zone_d = zone_q;
        case (zone_q)
            ZONE0: if (temp_q > UP01_W) zone_d = ZONE1;
            ZONE1: begin
                if (temp_q > UP12_W)      zone_d = ZONE2;
                else if (temp_q < DN10_W) zone_d = ZONE0;
            end
            ZONE2: if (temp_q < DN21_W) zone_d = ZONE1;
            default: zone_d = ZONE0;
        endcase

        // An illegal zone freezes the setpoint for the single recovery edge.
        if (zone_q != ZONE_BAD) begin
            if (load)             temp_d = lv_val[W-1:0];
            else if (inc && !dec) temp_d = up_val[W-1:0];
            else if (dec && !inc) temp_d = dn_val[W-1:0];
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            temp_q    <= INIT_W;
            zone_q    <= ZONE0;
            at_min_q  <= INIT_AT_MIN;
            at_max_q  <= INIT_AT_MAX;
            changed_q <= 1'b0;
        end else begin
            temp_q    <= temp_d;
            zone_q    <= zone_d;
            at_min_q  <= (temp_d == MIN_X[W-1:0]);
            at_max_q  <= (temp_d == MAX_X[W-1:0]);
            changed_q <= (temp_d != temp_q);
        end
    end

    assign temp    = temp_q;
    assign zone    = zone_q;
    assign at_min  = at_min_q;
    assign at_max  = at_max_q;
    assign changed = changed_q;

endmodule
